// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, prescale floor
// and the frame-length helper.
package uart_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_PRESCALE = 4;

    // Start + data + optional parity + stop + optional second stop.
    function automatic logic [3:0] frame_len(input int data_w, input logic par_en, input logic stop2);
        return 4'(2 + data_w + int'(par_en) + int'(stop2));
    endfunction

endpackage

// File: rtl/rx_bit_timer_if.sv
// Control and timing-status bundle between the receiver front end and the bit timer.
interface rx_bit_timer_if #(
    parameter int PRESC_W = 6
);
    logic               enable;
    logic               clear;
    logic [PRESC_W-1:0] prescale;
    logic               par_en;
    logic               stop2;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               sample_en;
    logic [1:0]         sample_idx;
    logic               bit_done;
    logic               frame_done;
    logic               busy;

    modport master (
        output enable, clear, prescale, par_en, stop2,
        input  edge_cnt, bit_cnt, sample_en, sample_idx, bit_done, frame_done, busy
    );

    modport slave (
        input  enable, clear, prescale, par_en, stop2,
        output edge_cnt, bit_cnt, sample_en, sample_idx, bit_done, frame_done, busy
    );
endinterface

// File: rtl/rx_sample_decode.sv
// Flags the three mid-bit sample edges (M-1, M, M+1 with M = P/2) and numbers them 0..2.
module rx_sample_decode #(
    parameter int PRESC_W = 6
) (
    input  logic               active,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sample_en,
    output logic [1:0]         sample_idx
);
    logic [PRESC_W-1:0] mid;
    logic [2:0]         hit;

    assign mid = prescale >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hit
            assign hit[gi] = active && (edge_cnt == mid + PRESC_W'(gi) - PRESC_W'(1));
        end
    endgenerate

    assign sample_en  = |hit;
    assign sample_idx = hit[2] ? 2'd2 : (hit[1] ? 2'd1 : 2'd0);
endmodule

// File: rtl/rx_bit_timer.sv
// Oversampled bit/edge timer for a UART receiver: tracks edge and bit position
// through one frame and pulses sample, bit-end and frame-end strobes.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input logic           clk,
    input logic           rst,
    rx_bit_timer_if.slave bus
);
    state_t             state_reg, state_next;
    logic [PRESC_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [3:0]         bit_cnt_reg, bit_cnt_next;
    logic [3:0]         n_reg, n_next;
    logic [PRESC_W-1:0] presc_clamped;
    logic               running;
    logic               last_edge;
    logic               frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            presc_reg    <= PRESC_W'(MIN_PRESCALE);
            n_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            presc_reg    <= presc_next;
            n_reg        <= n_next;
        end
    end

    assign presc_clamped = (bus.prescale < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE)
                                                                   : bus.prescale;
    assign running = (state_reg == RUN);

    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        presc_next    = presc_reg;
        n_next        = n_reg;
        last_edge     = running && (edge_cnt_reg == presc_reg - PRESC_W'(1));
        // An abort (clear or loss of enable) wins over a coincident frame end.
        frame_end     = last_edge && (bit_cnt_reg == n_reg - 4'd1) && bus.enable && !bus.clear;

        case (state_reg)
            IDLE: begin
                if (bus.enable && !bus.clear) begin
                    state_next    = RUN;
                    presc_next    = presc_clamped;
                    n_next        = frame_len(DATA_W, bus.par_en, bus.stop2);
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                end
            end
            RUN: begin
                if (bus.clear || !bus.enable || frame_end) begin
                    state_next    = IDLE;
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                end else if (last_edge) begin
                    edge_cnt_next = '0;
                    bit_cnt_next  = bit_cnt_reg + 4'd1;
                end else begin
                    edge_cnt_next = edge_cnt_reg + PRESC_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                edge_cnt_next = '0;
                bit_cnt_next  = '0;
            end
        endcase
    end

    rx_sample_decode #(
        .PRESC_W(PRESC_W)
    ) u_sample_decode (
        .active    (running),
        .edge_cnt  (edge_cnt_reg),
        .prescale  (presc_reg),
        .sample_en (bus.sample_en),
        .sample_idx(bus.sample_idx)
    );

    assign bus.edge_cnt   = edge_cnt_reg;
    assign bus.bit_cnt    = bit_cnt_reg;
    assign bus.bit_done   = last_edge;
    assign bus.frame_done = frame_end;
    assign bus.busy       = running;
endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: a time-based frame model predicts every cycle's outputs.
module tb_rx_bit_timer;
    localparam int DATA_W  = 8;
    localparam int PRESC_W = 6;

    typedef struct {
        int ecnt;
        int bcnt;
        int se;
        int si;
        int bd;
        int fd;
        int bsy;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    out_t exp_q[$];
    out_t obs;

    // Model state: cycles since frame entry, latched prescale and frame length.
    int   m_run = 0;
    int   m_t = 0;
    int   m_p = 4;
    int   m_n = 0;

    rx_bit_timer_if #(.PRESC_W(PRESC_W)) bus ();

    rx_bit_timer #(
        .DATA_W (DATA_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic out_t model_out(input logic en, input logic clr);
        out_t o;
        int   m;
        o = '{default: 0};
        if (m_run != 0) begin
            o.bsy  = 1;
            o.ecnt = m_t % m_p;
            o.bcnt = m_t / m_p;
            o.bd   = (o.ecnt == m_p - 1) ? 1 : 0;
            o.fd   = (o.bd == 1 && o.bcnt == m_n - 1 && en && !clr) ? 1 : 0;
            m      = m_p / 2;
            if (o.ecnt >= m - 1 && o.ecnt <= m + 1) begin
                o.se = 1;
                o.si = o.ecnt - (m - 1);
            end
        end
        return o;
    endfunction

    function automatic void model_update(input logic en, input logic clr, input int presc,
                                         input logic par, input logic s2);
        out_t o;
        o = model_out(en, clr);
        if (m_run == 0) begin
            if (en && !clr) begin
                m_run = 1;
                m_t   = 0;
                m_p   = (presc < 4) ? 4 : presc;
                m_n   = 2 + DATA_W + int'(par) + int'(s2);
            end
        end else if (clr || !en || o.fd == 1) begin
            m_run = 0;
            m_t   = 0;
        end else begin
            m_t++;
        end
    endfunction

    // One clock: drive, predict, observe on the falling edge, then advance the model.
    task automatic step(input logic en, input logic clr, input int presc, input logic par, input logic s2);
        out_t e;
        bus.enable   = en;
        bus.clear    = clr;
        bus.prescale = PRESC_W'(presc);
        bus.par_en   = par;
        bus.stop2    = s2;
        exp_q.push_back(model_out(en, clr));
        @(negedge clk);
        obs.ecnt = int'(bus.edge_cnt);
        obs.bcnt = int'(bus.bit_cnt);
        obs.se   = int'(bus.sample_en);
        obs.si   = int'(bus.sample_idx);
        obs.bd   = int'(bus.bit_done);
        obs.fd   = int'(bus.frame_done);
        obs.bsy  = int'(bus.busy);
        e = exp_q.pop_front();
        $display("cyc t=%0t en=%0b clr=%0b busy=%0d bit=%0d edge=%0d se=%0d si=%0d bd=%0d fd=%0d",
                 $time, en, clr, obs.bsy, obs.bcnt, obs.ecnt, obs.se, obs.si, obs.bd, obs.fd);
        check_value("edge_cnt", obs.ecnt, e.ecnt);
        check_value("bit_cnt", obs.bcnt, e.bcnt);
        check_value("sample_en", obs.se, e.se);
        check_value("sample_idx", obs.si, e.si);
        check_value("bit_done", obs.bd, e.bd);
        check_value("frame_done", obs.fd, e.fd);
        check_value("busy", obs.bsy, e.bsy);
        @(posedge clk);
        model_update(en, clr, presc, par, s2);
        #1;
    endtask

    // Runs with enable high until frame_done is seen; prescale switches to presc_late once bit 3 is reached.
    task automatic run_frame(input int presc, input logic par, input logic s2, input int presc_late,
                             output int run_cycles, output int bd_count);
        int p;
        p          = presc;
        run_cycles = 0;
        bd_count   = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, p, par, s2);
            if (obs.bsy == 1) run_cycles++;
            if (obs.bd == 1) bd_count++;
            if (obs.bsy == 1 && obs.bcnt == 3) p = presc_late;
            if (obs.fd == 1) return;
        end
        check_value("frame_timeout", 0, 1);
    endtask

    task automatic step_until(input int presc, input int bit_t, input int edge_t);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, presc, 1'b0, 1'b0);
            if (obs.bsy == 1 && obs.bcnt == bit_t && obs.ecnt == edge_t) return;
        end
        check_value("position_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_busy"}, int'(bus.busy), 0);
        check_value({tag, "_edge"}, int'(bus.edge_cnt), 0);
        check_value({tag, "_bit"}, int'(bus.bit_cnt), 0);
        check_value({tag, "_pulses"}, int'({bus.sample_en, bus.bit_done, bus.frame_done}), 0);
        check_value({tag, "_sidx"}, int'(bus.sample_idx), 0);
    endtask

    initial begin
        int rc;
        int bd;
        bus.enable   = 1'b1;
        bus.clear    = 1'b0;
        bus.prescale = PRESC_W'(8);
        bus.par_en   = 1'b0;
        bus.stop2    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        bus.enable = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 8N1 at P=8 with enable held high, then back-to-back restart.
        run_frame(8, 1'b0, 1'b0, 8, rc, bd);
        check_value("n8_run_cycles", rc, 80);
        check_value("n8_bit_done_count", bd, 10);
        step(1'b1, 1'b0, 8, 1'b0, 1'b0);
        check_value("busy_after_frame", obs.bsy, 0);
        step(1'b1, 1'b0, 8, 1'b0, 1'b0);
        check_value("restart_busy", obs.bsy, 1);
        check_value("restart_edge", obs.ecnt, 0);
        repeat (2) step(1'b0, 1'b0, 8, 1'b0, 1'b0);

        // Parity and two stops at P=16.
        run_frame(16, 1'b1, 1'b1, 16, rc, bd);
        check_value("n12_fd_bit", obs.bcnt, 11);
        check_value("n12_fd_edge", obs.ecnt, 15);
        check_value("n12_bit_done_count", bd, 12);
        check_value("n12_run_cycles", rc, 192);

        // Prescale change mid-frame takes effect only on the next frame.
        run_frame(8, 1'b0, 1'b0, 32, rc, bd);
        check_value("latched_p8_cycles", rc, 80);
        run_frame(32, 1'b0, 1'b0, 32, rc, bd);
        check_value("next_p32_cycles", rc, 320);
        step(1'b0, 1'b0, 8, 1'b0, 1'b0);

        // Enable dropped mid-frame.
        step_until(8, 4, 1);
        step(1'b0, 1'b0, 8, 1'b0, 1'b0);
        check_value("drop_bit", obs.bcnt, 4);
        check_value("drop_edge", obs.ecnt, 2);
        check_value("drop_fd", obs.fd, 0);
        step(1'b0, 1'b0, 8, 1'b0, 1'b0);
        check_value("drop_idle_busy", obs.bsy, 0);
        check_value("drop_idle_cnt", obs.bcnt + obs.ecnt, 0);

        // Clear on the frame_done cycle.
        step_until(4, 9, 2);
        step(1'b1, 1'b1, 4, 1'b0, 1'b0);
        check_value("clear_bd", obs.bd, 1);
        check_value("clear_fd", obs.fd, 0);
        step(1'b1, 1'b0, 4, 1'b0, 1'b0);
        check_value("clear_next_busy", obs.bsy, 0);
        step(1'b0, 1'b0, 4, 1'b0, 1'b0);

        // Prescale below the floor behaves as 4.
        run_frame(2, 1'b0, 1'b0, 2, rc, bd);
        check_value("p2_fd_edge", obs.ecnt, 3);
        check_value("p2_run_cycles", rc, 40);
        step(1'b0, 1'b0, 8, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, then a clean frame afterwards.
        step_until(8, 2, 5);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        m_run = 0;
        m_t   = 0;
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_value("post_rst_busy", int'(bus.busy), 0);
        run_frame(8, 1'b0, 1'b0, 8, rc, bd);
        check_value("post_rst_cycles", rc, 80);
        step(1'b0, 1'b0, 8, 1'b0, 1'b0);

        check_value("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_bit_timer.md
RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PRESC_W, default 6, width of the prescale and edge count.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  high while the receiver tracks a frame.
REQ-006 SHALL have port clear  input  1  synchronous abort; returns the block to idle.
REQ-007 SHALL have port prescale  input  PRESC_W  oversampling edges per bit.
REQ-008 SHALL have port par_en  input  1  a parity bit is present in the frame.
REQ-009 SHALL have port stop2  input  1  the frame has two stop bits.
REQ-010 SHALL have port edge_cnt  output  PRESC_W  current edge index within the bit.
REQ-011 SHALL have port bit_cnt  output  4  current bit index within the frame; start bit = 0.
REQ-012 SHALL have port sample_en  output  1  high on the three mid-bit sample edges.
REQ-013 SHALL have port sample_idx  output  2  sample number 0/1/2 while sample_en is high, else 0.
REQ-014 SHALL have port bit_done  output  1  one-cycle pulse on the last edge of each bit.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse on the last edge of the final bit.
REQ-016 SHALL have port busy  output  1  high in state RUN.

Function
REQ-017 SHALL implement an FSM with states IDLE and RUN.
REQ-018 SHALL move IDLE->RUN on the first cycle with enable=1 and clear=0.
REQ-019 SHALL latch prescale and frame length on that transition; later changes to prescale, par_en or stop2 SHALL NOT affect the frame in progress.
REQ-020 SHALL set frame length N = 1 + DATA_W + par_en + 1 + stop2, giving 7..13 bits.
REQ-021 SHALL clamp a latched prescale below 4 to 4.
REQ-022 SHALL increment edge_cnt by 1 each RUN cycle, starting from 0 on the first RUN cycle.
REQ-023 SHALL assert bit_done when edge_cnt = P-1, where P is the latched prescale.
REQ-024 SHALL wrap edge_cnt to 0 on the cycle after bit_done, and bit_cnt SHALL increment by 1 on that same cycle.
REQ-025 SHALL let M = P>>1 and assert sample_en when edge_cnt equals M-1, M or M+1, with sample_idx = 0, 1 and 2 respectively.
REQ-026 SHALL assert frame_done, together with bit_done, when edge_cnt = P-1 and bit_cnt = N-1.
REQ-027 SHALL return to IDLE on the cycle after frame_done, with edge_cnt and bit_cnt both 0, even if enable is still high.
REQ-028 SHALL restart from IDLE->RUN on the next cycle with enable=1 after a completed frame; the block SHALL spend at least one cycle in IDLE between frames.
REQ-029 SHALL go to IDLE with both counters 0 on the next edge when enable=0 in RUN, without asserting frame_done.
REQ-030 SHALL give clear priority over enable and over a coincident frame_done: the next state is IDLE with counters 0, and frame_done SHALL NOT assert in that cycle.
REQ-031 SHALL drive sample_en, bit_done and frame_done combinationally from the registered state, so they are low whenever the block is in IDLE.

Reset
REQ-032 SHALL, while rst=0, set the state to IDLE, edge_cnt=0, bit_cnt=0, the latched prescale to 4 and the latched N to 0, and drive all pulse outputs and busy to 0.
REQ-033 SHALL abandon a frame in progress when rst asserts mid-frame, and resume only via REQ-018 after rst releases.

Structure
REQ-034 SHALL place the FSM state encoding, the MIN_PRESCALE=4 constant and the frame-length function in the shared package uart_rx_pkg.
REQ-035 SHALL instantiate one sub-module, rx_sample_decode, which maps edge_cnt and the latched prescale to sample_en and sample_idx.

Verification
REQ-036 SHALL cover: DATA_W=8, prescale=8, par_en=0, stop2=0, enable held high -> sample_en at edge_cnt 3/4/5, 10 bit_done pulses, frame_done at cycle 80 after entry, busy=0 on cycle 81.
REQ-037 SHALL cover: prescale=16, par_en=1, stop2=1 -> N=12, frame_done at bit_cnt=11, edge_cnt=15; sample_en at edges 7/8/9.
REQ-038 SHALL cover: prescale changed from 8 to 32 during bit 3 -> the frame completes at P=8; the next frame uses P=32.
REQ-039 SHALL cover: enable dropped at bit_cnt=4, edge_cnt=2 -> the next cycle shows IDLE, both counters 0, and no frame_done.
REQ-040 SHALL cover: clear asserted on the frame_done cycle -> frame_done=0 and the next state is IDLE.
REQ-041 SHALL cover: prescale=2 -> behaves as 4, with sample_en at edges 1/2/3 and bit_done at edge 3.
